calc1_core: RTL and testbench



---
 rtl/calc1_pkg.sv | 30 +++
 rtl/calc1_if.sv | 38 +++
 rtl/calc1_port.sv | 91 +++++++++
 rtl/calc1_core.sv | 50 +++++
 tb/tb_calc1_core.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc1_pkg.sv
// calc1 shared definitions: widths, command/response encodings, port FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package calc1_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 4;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OP2  = 1'b1
  } state_t;

  // True for the four commands that start a two-cycle request.
  function automatic logic cmd_is_op(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
           (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc1_if.sv
// Request/response bundle for the four calculator ports.
// Latency: n/a (wiring only).
// Backpressure: none; requestors may issue one request every two cycles per port.
interface calc1_if;
  import calc1_pkg::*;

  logic [0:3]        req1_cmd_in;
  logic [0:3]        req2_cmd_in;
  logic [0:3]        req3_cmd_in;
  logic [0:3]        req4_cmd_in;
  logic [0:DATA_W-1] req1_data_in;
  logic [0:DATA_W-1] req2_data_in;
  logic [0:DATA_W-1] req3_data_in;
  logic [0:DATA_W-1] req4_data_in;
  logic [0:DATA_W-1] out_data1;
  logic [0:DATA_W-1] out_data2;
  logic [0:DATA_W-1] out_data3;
  logic [0:DATA_W-1] out_data4;
  logic [0:1]        out_resp1;
  logic [0:1]        out_resp2;
  logic [0:1]        out_resp3;
  logic [0:1]        out_resp4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_data1, out_data2, out_data3, out_data4,
    input  out_resp1, out_resp2, out_resp3, out_resp4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_data1, out_data2, out_data3, out_data4,
    output out_resp1, out_resp2, out_resp3, out_resp4
  );

endinterface

// File: rtl/calc1_port.sv
// One calculator port: command+operand1 cycle, operand2 cycle, registered one-cycle result.
// Latency: result registered at the operand2 edge; invalid command flagged at its own edge.
// Backpressure: none; operand2-cycle command input is ignored, next request may follow directly.
module calc1_port
  import calc1_pkg::*;
(
  input  logic              c_clk,
  input  logic              rst,
  input  logic [0:3]        i_cmd,
  input  logic [0:DATA_W-1] i_data,
  output logic [0:DATA_W-1] o_data,
  output logic [0:1]        o_resp
);

  state_t            r_state;
  logic [0:3]        r_cmd;
  logic [0:DATA_W-1] r_op1;

  logic [DATA_W:0]   w_sum;
  logic [4:0]        w_shamt;
  logic [1:0]        w_resp;
  logic [0:DATA_W-1] w_data;

  // Carry out lands in w_sum[DATA_W]; shift amount is the five least significant bits.
  assign w_sum   = {1'b0, r_op1} + {1'b0, i_data};
  assign w_shamt = i_data[DATA_W-5:DATA_W-1];

  // ALU: combine latched operand1/cmd with operand2 on the input bus; errors force data to 0.
  always_comb begin
    w_resp = RESP_ERR;
    w_data = '0;
    case (r_cmd)
      CMD_ADD: begin
        if (!w_sum[DATA_W]) begin
          w_resp = RESP_OK;
          w_data = w_sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (i_data <= r_op1) begin
          w_resp = RESP_OK;
          w_data = r_op1 - i_data;
        end
      end
      CMD_SHL: begin
        w_resp = RESP_OK;
        w_data = r_op1 << w_shamt;
      end
      CMD_SHR: begin
        w_resp = RESP_OK;
        w_data = r_op1 >> w_shamt;
      end
      default: begin
        w_resp = RESP_ERR;
        w_data = '0;
      end
    endcase
  end

  // Port FSM with registered outputs; outputs fall back to NONE/0 unless a result is produced.
  always_ff @(posedge c_clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cmd   <= CMD_NOP;
      r_op1   <= '0;
      o_resp  <= RESP_NONE;
      o_data  <= '0;
    end else begin
      o_resp <= RESP_NONE;
      o_data <= '0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_is_op(i_cmd)) begin
            r_cmd   <= i_cmd;
            r_op1   <= i_data;
            r_state <= ST_OP2;
          end else if (i_cmd != CMD_NOP) begin
            o_resp <= RESP_ERR;
          end
        end
        ST_OP2: begin
          o_resp  <= w_resp;
          o_data  <= w_data;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/calc1_core.sv
// Four independent calculator ports behind one interface bundle.
// Latency: per port, result one edge after operand2; all ports share the same timing.
// Backpressure: none; no arbitration or ordering between ports.
module calc1_core
  import calc1_pkg::*;
(
  input  logic        c_clk,
  input  logic [1:7]  reset,
  calc1_if.slave      bus
);

  logic              w_rst;
  logic [0:3]        w_cmd   [NUM_PORTS];
  logic [0:DATA_W-1] w_din   [NUM_PORTS];
  logic [0:DATA_W-1] w_dout  [NUM_PORTS];
  logic [0:1]        w_resp  [NUM_PORTS];

  // Any asserted reset bit clears the whole block.
  assign w_rst = |reset;

  assign w_cmd[0] = bus.req1_cmd_in;
  assign w_cmd[1] = bus.req2_cmd_in;
  assign w_cmd[2] = bus.req3_cmd_in;
  assign w_cmd[3] = bus.req4_cmd_in;
  assign w_din[0] = bus.req1_data_in;
  assign w_din[1] = bus.req2_data_in;
  assign w_din[2] = bus.req3_data_in;
  assign w_din[3] = bus.req4_data_in;

  assign bus.out_data1 = w_dout[0];
  assign bus.out_data2 = w_dout[1];
  assign bus.out_data3 = w_dout[2];
  assign bus.out_data4 = w_dout[3];
  assign bus.out_resp1 = w_resp[0];
  assign bus.out_resp2 = w_resp[1];
  assign bus.out_resp3 = w_resp[2];
  assign bus.out_resp4 = w_resp[3];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    calc1_port u_port (
      .c_clk  (c_clk),
      .rst    (w_rst),
      .i_cmd  (w_cmd[g]),
      .i_data (w_din[g]),
      .o_data (w_dout[g]),
      .o_resp (w_resp[g])
    );
  end

endmodule

// File: tb/tb_calc1_core.sv
// Randomised scoreboard bench for calc1_core against an arithmetic reference model.
module tb_calc1_core;

  logic       c_clk = 1'b0;
  logic [1:7] reset;

  always #5 c_clk = ~c_clk;

  calc1_if bus ();

  calc1_core dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [31:0] dout [4];
  logic [1:0]  resp [4];

  assign bus.req1_cmd_in  = cmd[0];
  assign bus.req2_cmd_in  = cmd[1];
  assign bus.req3_cmd_in  = cmd[2];
  assign bus.req4_cmd_in  = cmd[3];
  assign bus.req1_data_in = din[0];
  assign bus.req2_data_in = din[1];
  assign bus.req3_data_in = din[2];
  assign bus.req4_data_in = din[3];
  assign dout[0] = bus.out_data1;
  assign dout[1] = bus.out_data2;
  assign dout[2] = bus.out_data3;
  assign dout[3] = bus.out_data4;
  assign resp[0] = bus.out_resp1;
  assign resp[1] = bus.out_resp2;
  assign resp[2] = bus.out_resp3;
  assign resp[3] = bus.out_resp4;

  int unsigned edge_cnt = 0;
  always @(posedge c_clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int unsigned due;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t expq [4][$];
  int tests = 0;
  int fails = 0;

  logic [3:0]  t_cmd [4];
  logic [31:0] t_a   [4];
  logic [31:0] t_b   [4];

  function automatic bit is_op(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  // Reference: plain arithmetic on unsigned values.
  function automatic void ref_model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [1:0] r, output logic [31:0] d);
    longint unsigned s;
    r = 2'd2;
    d = 32'd0;
    case (c)
      4'd1: begin
        s = {32'd0, a} + {32'd0, b};
        if (s < 64'h1_0000_0000) begin r = 2'd1; d = s[31:0]; end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << (b % 32); end
      4'd6: begin r = 2'd1; d = a >> (b % 32); end
      default: begin r = 2'd2; d = 32'd0; end
    endcase
  endfunction

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Present t_cmd/t_a on all ports, then t_b for ports that started an operation.
  task automatic issue();
    bit any_op;
    exp_t e;
    logic [1:0] r;
    logic [31:0] d;
    @(negedge c_clk);
    any_op = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = t_cmd[p];
      din[p] = t_a[p];
      if (is_op(t_cmd[p])) any_op = 1'b1;
      else if (t_cmd[p] != 4'd0) begin
        e.due = edge_cnt + 1; e.resp = 2'd2; e.data = 32'd0;
        expq[p].push_back(e);
      end
    end
    if (any_op) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        if (is_op(t_cmd[p])) begin
          cmd[p] = 4'($urandom);
          din[p] = t_b[p];
          ref_model(t_cmd[p], t_a[p], t_b[p], r, d);
          e.due = edge_cnt + 1; e.resp = r; e.data = d;
          expq[p].push_back(e);
        end else begin
          cmd[p] = 4'd0;
          din[p] = $urandom;
        end
      end
    end
  endtask

  task automatic single(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    for (int q = 0; q < 4; q++) begin
      t_cmd[q] = 4'd0; t_a[q] = $urandom; t_b[q] = $urandom;
    end
    t_cmd[p] = c; t_a[p] = a; t_b[p] = b;
    issue();
  endtask

  task automatic idle(input int n);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = $urandom; end
    repeat (n - 1) @(negedge c_clk);
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  // Monitor: every cycle each port either shows its due result or NONE/0.
  initial begin
    forever begin
      @(posedge c_clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        exp_t e;
        while (expq[p].size() > 0 && expq[p][0].due < edge_cnt) begin
          tests++; fails++;
          $display("FAIL port%0d missed result due at edge %0d (expected resp=%0d data=%h)",
                   p + 1, expq[p][0].due, expq[p][0].resp, expq[p][0].data);
          void'(expq[p].pop_front());
        end
        if (expq[p].size() > 0 && expq[p][0].due == edge_cnt) begin
          e = expq[p].pop_front();
        end else begin
          e.due = edge_cnt; e.resp = 2'd0; e.data = 32'd0;
        end
        tests++;
        if (resp[p] !== e.resp || dout[p] !== e.data) begin
          fails++;
          $display("FAIL port%0d edge %0d: got resp=%0d data=%h, expected resp=%0d data=%h",
                   p + 1, edge_cnt, resp[p], dout[p], e.resp, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: stimulus did not complete within time limit");
    summary();
    $finish;
  end

  initial begin
    reset = 7'b1000000;
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'($urandom); din[p] = $urandom; end
    repeat (4) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin cmd[p] = 4'($urandom); din[p] = $urandom; end
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = $urandom; end
    reset = 7'b0000000;
    idle(4);

    // Add
    single(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
    single(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    single(0, 4'd1, 32'h0000_0000, 32'h0000_0000);
    single(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    single(0, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001);
    // Subtract
    single(0, 4'd2, 32'h0000_0001, 32'h0000_000F);
    single(0, 4'd2, 32'h0000_000F, 32'h0000_0001);
    single(0, 4'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Shifts on ports 1 and 2 concurrently
    for (int k = 0; k < 30; k++) begin
      for (int q = 0; q < 4; q++) begin t_cmd[q] = 4'd0; t_a[q] = $urandom; t_b[q] = $urandom; end
      t_cmd[0] = 4'd5; t_a[0] = 32'd1 << k;           t_b[0] = 32'd1;
      t_cmd[1] = 4'd6; t_a[1] = 32'h8000_0000 >> k;   t_b[1] = 32'd1;
      issue();
    end
    single(0, 4'd5, 32'h1234_5678, 32'h0000_0021);
    single(1, 4'd6, 32'h8765_4321, 32'hFFFF_FFE1);
    single(0, 4'd5, 32'hA5A5_A5A5, 32'h0000_0000);
    single(2, 4'd6, 32'hFFFF_FFFF, 32'h0000_001F);

    // Invalid commands, then a normal request
    single(0, 4'd3, $urandom, $urandom);
    single(0, 4'd4, $urandom, $urandom);
    single(0, 4'd1, 32'd5, 32'd7);
    single(3, 4'd15, $urandom, $urandom);
    idle(2);

    // Concurrency
    t_cmd[0] = 4'd1; t_a[0] = 32'h0000_1000; t_b[0] = 32'h0000_0234;
    t_cmd[1] = 4'd2; t_a[1] = 32'h0000_0100; t_b[1] = 32'h0000_0001;
    t_cmd[2] = 4'd5; t_a[2] = 32'h0000_00F0; t_b[2] = 32'h0000_0004;
    t_cmd[3] = 4'd6; t_a[3] = 32'hF000_0000; t_b[3] = 32'h0000_0008;
    issue();
    t_cmd[0] = 4'd0; t_a[0] = $urandom;      t_b[0] = $urandom;
    t_cmd[1] = 4'd1; t_a[1] = 32'h7FFF_FFFF; t_b[1] = 32'h8000_0001;
    t_cmd[2] = 4'd0; t_a[2] = $urandom;      t_b[2] = $urandom;
    t_cmd[3] = 4'd2; t_a[3] = 32'd3;         t_b[3] = 32'd9;
    issue();
    idle(2);

    // Reset mid-request (using a different reset bit) discards the partial request
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd1; din[p] = $urandom; end
    @(negedge c_clk);
    reset = 7'b0000001;
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'($urandom); din[p] = $urandom; end
    @(negedge c_clk);
    @(negedge c_clk);
    reset = 7'b0000000;
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = $urandom; end
    idle(2);
    single(0, 4'd1, 32'd2, 32'd3);

    // Random traffic, back-to-back, all ports
    repeat (300) begin
      for (int p = 0; p < 4; p++) begin
        case ($urandom_range(0, 7))
          0:       t_cmd[p] = 4'd0;
          1:       t_cmd[p] = 4'($urandom_range(7, 15));
          2:       t_cmd[p] = 4'($urandom_range(3, 4));
          3, 4:    t_cmd[p] = 4'($urandom_range(1, 2));
          default: t_cmd[p] = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'd6;
        endcase
        t_a[p] = rnd_data();
        t_b[p] = rnd_data();
      end
      issue();
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end

    idle(4);
    for (int p = 0; p < 4; p++) begin
      tests++;
      if (expq[p].size() != 0) begin
        fails++;
        $display("FAIL port%0d drain: %0d results still outstanding, expected 0", p + 1, expq[p].size());
      end
    end
    summary();
    $finish;
  end

endmodule
